// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter.
// Commands, FSM states and the RAM-select rule.
package ram_port_arbiter_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

  // Address MSB clear selects the RAM; set means outside it.
  function automatic logic in_ram(input logic msb);
    return !msb;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr2.sv
// Two-way round-robin picker: on a tie the port
// that did not win last time is chosen.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one sync RAM between two ports.
// Optional bus locking is built when ARB_LOCK_EN is defined.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 9,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        p0_cmd,
  input  logic [AW-1:0]     p0_addr,
  input  logic [DW-1:0]     p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DW-1:0]     p0_rdata,
  input  logic [1:0]        p1_cmd,
  input  logic [AW-1:0]     p1_addr,
  input  logic [DW-1:0]     p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DW-1:0]     p1_rdata,
`ifdef ARB_LOCK_EN
  input  logic              p0_lock,
  input  logic              p1_lock,
`endif
  output logic [RAM_AW-1:0] ram_read_address,
  output logic [RAM_AW-1:0] ram_write_address,
  output logic              ram_write,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              busy,
  output logic              last_grant
);

  state_e          state, state_nxt;
  logic            last_q;
  logic            rd_port_q;
  logic            rd_oor_q;
  logic [1:0]      req;
  logic [1:0]      pick;
  logic [1:0]      gnt;
  logic            sel;
  logic [1:0]      cmd;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            granted;
  logic            g_rd;
  logic            g_wr;

`ifdef ARB_LOCK_EN
  logic lock_q;
  logic owner_q;

  // While locked, only the owner may compete.
  always_comb begin
    req = {is_req(p1_cmd), is_req(p0_cmd)};
    if (lock_q)
      req = req & (owner_q ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else if (granted) begin
      lock_q  <= sel ? p1_lock : p0_lock;
      owner_q <= sel;
    end
  end
`else
  assign req = {is_req(p1_cmd), is_req(p0_cmd)};
`endif

  arb_rr2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

  assign gnt     = (reset && state == IDLE) ? pick : 2'b00;
  assign sel     = gnt[1];
  assign cmd     = sel ? p1_cmd : p0_cmd;
  assign addr    = sel ? p1_addr : p0_addr;
  assign wdata   = sel ? p1_wdata : p0_wdata;
  assign granted = |gnt;
  assign g_rd    = granted && (cmd == MREAD);
  assign g_wr    = granted && (cmd == MWRITE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last_q    <= 1'b1;
      rd_port_q <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (granted)
        last_q <= sel;
      if (g_rd) begin
        rd_port_q <= sel;
        rd_oor_q  <= !in_ram(addr[AW-1]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (g_rd) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = IDLE;
    endcase
  end

  // Read data leaves the RAM one cycle after the address.
  always_comb begin
    ram_write         = 1'b0;
    ram_write_address = '0;
    ram_din           = '0;
    ram_read_address  = '0;
    p0_rvalid         = 1'b0;
    p1_rvalid         = 1'b0;
    p0_rdata          = '0;
    p1_rdata          = '0;
    if (g_wr && in_ram(addr[AW-1])) begin
      ram_write         = 1'b1;
      ram_write_address = addr[RAM_AW-1:0];
      ram_din           = wdata;
    end
    if (g_rd)
      ram_read_address = addr[RAM_AW-1:0];
    if (reset && state == RD_WAIT) begin
      if (rd_port_q) begin
        p1_rvalid = 1'b1;
        p1_rdata  = rd_oor_q ? '0 : ram_dout;
      end else begin
        p0_rvalid = 1'b1;
        p0_rdata  = rd_oor_q ? '0 : ram_dout;
      end
    end
  end

  assign p0_gnt     = gnt[0];
  assign p1_gnt     = gnt[1];
  assign busy       = (state == RD_WAIT);
  assign last_grant = last_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, directed cases and a
// randomized run against a transaction-level reference model.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  p0_cmd = MNONE, p1_cmd = MNONE;
  logic [8:0]  p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [7:0]  ram_read_address, ram_write_address;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = '0;
  logic        busy, last_grant;
`ifdef ARB_LOCK_EN
  logic        p0_lock = 1'b0, p1_lock = 1'b0;
  logic        m_locked = 1'b0, m_owner = 1'b0;
`endif

  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];

  // reference model state
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic        m_rport = 1'b0;
  logic [15:0] m_rexp = '0;
  logic [1:0]  last_g = '0;
  logic [15:0] obs_rd0, obs_rd1;
  int          n_cmp = 0;
  int          n_bad = 0;

  ram_port_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .p0_cmd            (p0_cmd),
    .p0_addr           (p0_addr),
    .p0_wdata          (p0_wdata),
    .p0_gnt            (p0_gnt),
    .p0_rvalid         (p0_rvalid),
    .p0_rdata          (p0_rdata),
    .p1_cmd            (p1_cmd),
    .p1_addr           (p1_addr),
    .p1_wdata          (p1_wdata),
    .p1_gnt            (p1_gnt),
    .p1_rvalid         (p1_rvalid),
    .p1_rdata          (p1_rdata),
`ifdef ARB_LOCK_EN
    .p0_lock           (p0_lock),
    .p1_lock           (p1_lock),
`endif
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write         (ram_write),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout),
    .busy              (busy),
    .last_grant        (last_grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) ram[ram_write_address] <= ram_din;
    ram_dout <= ram[ram_read_address];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    logic       r0, r1, ew, gp;
    logic [1:0] eg, ev, gc;
    logic [8:0] ga;
    logic [15:0] gw;
    @(negedge clk);
    r0 = p0_cmd inside {MREAD, MWRITE};
    r1 = p1_cmd inside {MREAD, MWRITE};
`ifdef ARB_LOCK_EN
    if (m_locked) begin
      if (m_owner) r0 = 1'b0;
      else r1 = 1'b0;
    end
`endif
    eg = 2'b00;
    if (reset && !m_busy) begin
      if (r0 && r1) eg = m_last ? 2'b01 : 2'b10;
      else eg = {r1, r0};
    end
    gp = eg[1];
    gc = gp ? p1_cmd : p0_cmd;
    ga = gp ? p1_addr : p0_addr;
    gw = gp ? p1_wdata : p0_wdata;
    ew = (eg != 0) && gc == MWRITE && !ga[8];
    chk("gnt", {p1_gnt, p0_gnt}, eg);
    chk("ram_write", ram_write, ew);
    if (ew) begin
      chk("waddr", ram_write_address, ga[7:0]);
      chk("din", ram_din, gw);
    end
    if (eg != 0 && gc == MREAD)
      chk("raddr", ram_read_address, ga[7:0]);
    if (eg == 0 && !m_busy) begin
      chk("waddr_idle", ram_write_address, 0);
      chk("raddr_idle", ram_read_address, 0);
      chk("din_idle", ram_din, 0);
    end
    ev = (reset && m_busy) ? (m_rport ? 2'b10 : 2'b01) : 2'b00;
    chk("rvalid", {p1_rvalid, p0_rvalid}, ev);
    chk("rdata0", p0_rdata, ev[0] ? m_rexp : 16'h0);
    chk("rdata1", p1_rdata, ev[1] ? m_rexp : 16'h0);
    if (reset) begin
      chk("busy", busy, m_busy);
      chk("last_grant", last_grant, m_last);
    end
    obs_rd0 = p0_rdata;
    obs_rd1 = p1_rdata;
    last_g = eg;
    if (ew) ref_mem[ga[7:0]] = gw;
    @(posedge clk);
    if (!reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
`ifdef ARB_LOCK_EN
      m_locked = 1'b0;
`endif
    end else begin
      m_busy = 1'b0;
      if (eg != 0) begin
        m_last = gp;
        if (gc == MREAD) begin
          m_busy = 1'b1;
          m_rport = gp;
          m_rexp = ga[8] ? 16'h0 : ref_mem[ga[7:0]];
        end
`ifdef ARB_LOCK_EN
        m_locked = gp ? p1_lock : p0_lock;
        m_owner = gp;
`endif
      end
    end
    #1;
  endtask

  task automatic pick(output logic [1:0] c, output logic [8:0] a,
                      output logic [15:0] w);
    int r;
    r = $urandom_range(0, 5);
    c = (r == 0) ? MNONE : (r == 1) ? 2'b11 : (r < 4) ? MREAD : MWRITE;
    a = {($urandom_range(0, 7) == 0), 4'b0000, 4'($urandom_range(0, 15))};
    w = 16'($urandom);
  endtask

  initial begin
    int k, cnt0, cnt1, n1, budget;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      ref_mem[i] = ram[i];
    end

    // reset
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // write then read back
    p0_cmd = MWRITE; p0_addr = 9'h005; p0_wdata = 16'hBEEF;
    cycle();
    chk("t1_wgnt", last_g, 2'b01);
    p0_cmd = MNONE;
    cycle();
    p0_cmd = MREAD; p0_addr = 9'h005;
    cycle();
    chk("t1_rgnt", last_g, 2'b01);
    p0_cmd = MNONE;
    cycle();
    chk("t1_rdata", obs_rd0, 16'hBEEF);

    // alternation from reset with both ports reading
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    p0_cmd = MREAD; p0_addr = 9'h010;
    p1_cmd = MREAD; p1_addr = 9'h011;
    k = 0; cnt0 = 0; cnt1 = 0; budget = 0;
    while (k < 16 && budget < 60) begin
      cycle();
      budget++;
      if (last_g != 0) begin
        chk("t2_alt", last_g[1], k % 2);
        k++;
        if (last_g[0] && ++cnt0 == 8) p0_cmd = MNONE;
        if (last_g[1] && ++cnt1 == 8) p1_cmd = MNONE;
      end
    end
    chk("t2_count", k, 16);
    cycle();
    cycle();

    // out-of-range write and read
    p1_cmd = MWRITE; p1_addr = 9'h120; p1_wdata = 16'h1234;
    cycle();
    chk("t3_wgnt", last_g, 2'b10);
    p1_cmd = MREAD; p1_addr = 9'h140;
    cycle();
    chk("t3_rgnt", last_g, 2'b10);
    p1_cmd = MNONE;
    cycle();
    chk("t3_rdata", obs_rd1, 16'h0000);

    // reset aborts a pending read
    p0_cmd = MREAD; p0_addr = 9'h005;
    cycle();
    p0_cmd = MNONE;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    p0_cmd = MREAD; p1_cmd = MREAD;
    cycle();
    chk("t4_tie", last_g, 2'b01);
    p0_cmd = MNONE; p1_cmd = MNONE;
    cycle();

    // back-to-back writes then read back
    for (int i = 0; i < 4; i++) begin
      p0_cmd = MWRITE; p0_addr = 9'(i); p0_wdata = 16'hA000 + 16'(i);
      cycle();
      chk("t5_wgnt", last_g, 2'b01);
    end
    for (int i = 0; i < 4; i++) begin
      p0_cmd = MREAD; p0_addr = 9'(i);
      cycle();
      p0_cmd = MNONE;
      cycle();
      chk("t5_rdata", obs_rd0, 16'hA000 + 16'(i));
    end

`ifdef ARB_LOCK_EN
    // p1 holds the bus for three locked writes plus an unlocking one
    p1_cmd = MWRITE; p1_addr = 9'h030; p1_wdata = 16'h5555; p1_lock = 1'b1;
    n1 = 0; budget = 0;
    while (budget < 20) begin
      cycle();
      budget++;
      if (n1 > 0) begin
        p0_cmd = MREAD; p0_addr = 9'h031;
      end
      if (last_g[1]) begin
        n1++;
        p1_lock = (n1 < 3);
        if (n1 == 4) p1_cmd = MNONE;
      end
      if (last_g[0]) break;
    end
    chk("t6_lock_order", n1, 4);
    p0_cmd = MNONE; p1_cmd = MNONE; p1_lock = 1'b0;
    cycle();
`endif

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (last_g[0] || !(p0_cmd inside {MREAD, MWRITE})) begin
        pick(p0_cmd, p0_addr, p0_wdata);
`ifdef ARB_LOCK_EN
        p0_lock = ($urandom_range(0, 3) == 0);
`endif
      end
      if (last_g[1] || !(p1_cmd inside {MREAD, MWRITE})) begin
        pick(p1_cmd, p1_addr, p1_wdata);
`ifdef ARB_LOCK_EN
        p1_lock = ($urandom_range(0, 3) == 0);
`endif
      end
      reset = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter that shares the single 16-bit x 256-entry synchronous RAM between the CPU (port 0) and a secondary master (port 1, e.g. a program loader or DMA engine).
- Accepts MNONE/MREAD/MWRITE commands on each port and grants one per transaction, round-robin.
- Drives the RAM read/write address, write enable and data-in.
- Returns read data with a valid strobe that accounts for the RAM's one-cycle registered read.

Parameters:
DW, 16, data width of RAM words and ports
AW, 9, requester address width (bit AW-1 set = outside RAM)
RAM_AW, 8, RAM address width; RAM address = addr[RAM_AW-1:0]

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
p0_cmd  in  2  port 0 command: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 ignored as MNONE
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_gnt  out  1  port 0 command accepted this cycle
p0_rvalid  out  1  port 0 read data valid this cycle
p0_rdata  out  DW  port 0 read data
p1_cmd, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
ram_read_address  out  RAM_AW  to RAM read address
ram_write_address  out  RAM_AW  to RAM write address
ram_write  out  1  RAM write enable
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM registered read data
busy  out  1  high in RD_WAIT
last_grant  out  1  index of most recently granted port

Behaviour:
- States:
  - IDLE: accepts a command.
  - RD_WAIT: waits for RAM data; no grants.
- Request rule: a requester holds cmd/addr/wdata stable while cmd != MNONE until its gnt. The cycle after gnt it presents its next command or MNONE.
- IDLE, single requester: grant it. Both requesting: grant the port != last_grant.
  - gnt is combinational, in the same cycle as the request.
  - last_grant updates at the next edge.
- Granted MWRITE:
  - ram_write = 1 when addr[AW-1] = 0. ram_write_address = addr[RAM_AW-1:0], ram_din = wdata.
  - Completes in that cycle; state stays IDLE.
  - addr[AW-1] = 1: ram_write = 0, write dropped, gnt still asserted.
- Granted MREAD:
  - ram_read_address = addr[RAM_AW-1:0]. Store the winner index and an out-of-range flag; go to RD_WAIT.
  - RD_WAIT (exactly one cycle): the winner's rvalid = 1. rdata = ram_dout, or 16'h0000 if out of range. Return to IDLE.
  - Read latency is gnt -> rvalid of 1 cycle. Read throughput is one per 2 cycles; write throughput is one per cycle.
- Outputs when not granted / not valid:
  - ram_write = 0.
  - Both gnt = 0 and both rvalid = 0.
  - rdata = 0 and ram_din = 0.
  - ram_read_address/ram_write_address hold 0 when idle with no grant.
- Reset (reset = 0 at an edge):
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - Stored winner and flag are cleared. Outputs are as in the idle state.
  - Reset during RD_WAIT aborts the read; no rvalid is issued.
- Simultaneous write requests to the same address from both ports: serialized by round-robin; the later grant's data persists.

Optional Feature:
Macro: ARB_LOCK_EN.
- Defined:
  - Adds p0_lock and p1_lock inputs (1 bit each).
  - If the granted port has lock = 1 at its grant, it owns the arbiter: the other port is not granted until the owner receives a grant with lock = 0.
  - Owner cmd MNONE while locked: no grants to anyone (intentional starvation; a locked bus is held).
  - Reset clears ownership.
- Undefined: lock ports do not exist; pure round-robin.

Decomposition:
- Shared defines file holds:
  - MNONE/MREAD/MWRITE command encodings.
  - IDLE/RD_WAIT state encodings.
  - RAM-select rule (addr[AW-1] == 0).
- One sub-module, arb_rr2: combinational 2-way round-robin picker (req[1:0], last -> grant[1:0]), instantiated once.

Test Plan:
- Reset then p0 MWRITE addr 9'h005 data 16'hBEEF -> same-cycle p0_gnt, ram_write = 1, ram_write_address = 8'h05. Later p0 MREAD 9'h005 -> p0_rvalid next cycle, p0_rdata = 16'hBEEF.
- Both ports MREAD (p0 9'h010, p1 9'h011) from reset -> p0 granted first, p0_rvalid, then p1 granted in the following IDLE cycle, p1_rvalid. Alternation holds over 8 transactions each.
- p1 MWRITE 9'h120 data 16'h1234 -> p1_gnt, ram_write stays 0. p1 MREAD 9'h140 -> p1_rvalid, p1_rdata = 16'h0000.
- Reset driven low in the cycle after a p0 MREAD grant -> no p0_rvalid, state IDLE, next tie goes to p0.
- Back-to-back p0 writes to 9'h000..9'h003 with p1 idle -> four gnt in four consecutive cycles. Subsequent reads return the written data.
- ARB_LOCK_EN: p1 locked for 3 writes while p0 requests continuously -> p0_gnt only after p1's grant with p1_lock = 0.
